// File: rtl/dtree_pkg.sv
// dtree_pkg: shared types and helpers for the decision-tree label queue.
//   leaf_idx_width() - leaf index width, 2*$clog2(FEATURES)
//   label_t          - class label type at the default label width
//   sat_inc()        - saturating increment used by the drop and class counters
package dtree_pkg;

    localparam int unsigned LABEL_W_DEFAULT = 2;

    typedef logic [LABEL_W_DEFAULT-1:0] label_t;

    // Leaf index is {level, path}, each $clog2(FEATURES) bits wide.
    function automatic int unsigned leaf_idx_width(input int unsigned features);
        return 2 * $clog2(features);
    endfunction

    // Increment value, holding at the all-ones value of a width-bit counter.
    // Counters up to 32 bits are supported.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/label_fifo.sv
// label_fifo: synchronous FIFO holding class labels.
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset; clears pointers and storage
//   i_push   in   push request with i_data
//   i_data   in   WIDTH-bit entry to push
//   i_pop    in   pop request; ignored while empty
//   o_full   out  DEPTH entries held
//   o_empty  out  no entries held
//   o_head   out  oldest entry, read straight from the storage registers
// A push while full is accepted only when a pop happens in the same cycle.
module label_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra MSB on each pointer separates full from empty when the low bits match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // When full, the slot being written is the one being popped this cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[PW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dtree_label_queue.sv
// dtree_label_queue: maps decision-tree leaves to class labels and queues them.
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   level, path  in   leaf depth / path bits from the tree
//   in_valid     in   one-cycle strobe qualifying level/path
//   cfg_we       in   label table write enable
//   cfg_addr     in   leaf index {level, path} to write
//   cfg_label    in   label to write
//   label        out  FIFO head label
//   label_valid  out  FIFO not empty
//   label_ready  in   consumer accepts head while label_valid
//   drop_count   out  saturating count of labels lost to a full FIFO
//   count_sel    in   class counter select         (DTREE_CLASS_COUNT_EN only)
//   count_out    out  selected class count         (DTREE_CLASS_COUNT_EN only)
//   count_clear  in   synchronous clear of counters (DTREE_CLASS_COUNT_EN only)
// Optional feature macro: DTREE_CLASS_COUNT_EN enables per-class lookup counters.
module dtree_label_queue
    import dtree_pkg::*;
#(
    parameter  int unsigned FEATURES    = 3,
    parameter  int unsigned LABEL_WIDTH = 2,
    parameter  int unsigned DEPTH       = 8,
    parameter  int unsigned COUNT_WIDTH = 16,
    localparam int unsigned LW          = $clog2(FEATURES),
    localparam int unsigned IW          = leaf_idx_width(FEATURES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LW-1:0]          level,
    input  logic [LW-1:0]          path,
    input  logic                   in_valid,
    input  logic                   cfg_we,
    input  logic [IW-1:0]          cfg_addr,
    input  logic [LABEL_WIDTH-1:0] cfg_label,
    output logic [LABEL_WIDTH-1:0] label,
    output logic                   label_valid,
    input  logic                   label_ready,
`ifdef DTREE_CLASS_COUNT_EN
    input  logic [LABEL_WIDTH-1:0] count_sel,
    output logic [COUNT_WIDTH-1:0] count_out,
    input  logic                   count_clear,
`endif
    output logic [COUNT_WIDTH-1:0] drop_count
);

    localparam int unsigned TABLE_N = 1 << IW;

    logic [LABEL_WIDTH-1:0] r_table [TABLE_N];
    logic [IW-1:0]          r_s1_idx;
    logic                   r_s1_valid;
    logic [COUNT_WIDTH-1:0] r_drop_count;

    logic [LABEL_WIDTH-1:0] w_lookup;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_drop;
    logic [COUNT_WIDTH-1:0] w_drop_inc;

    // Stage 1: capture the leaf index; s1_valid follows the strobe each cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_idx <= {level, path};
            end
        end
    end

    // Label table; a write lands on the edge, so a same-cycle lookup sees the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(TABLE_N); i++) begin
                r_table[i] <= '0;
            end
        end else if (cfg_we) begin
            r_table[cfg_addr] <= cfg_label;
        end
    end

    // Stage 2: combinational lookup feeds the FIFO push.
    assign w_lookup    = r_table[r_s1_idx];
    assign label_valid = !w_empty;
    assign w_pop       = label_valid && label_ready;
    assign w_drop      = r_s1_valid && w_full && !w_pop;

    label_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LABEL_WIDTH)
    ) u_label_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_s1_valid),
        .i_data  (w_lookup),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (label)
    );

    always_comb begin
        w_drop_inc = COUNT_WIDTH'(sat_inc(32'(r_drop_count), COUNT_WIDTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_drop_count <= w_drop_inc;
        end
    end

    assign drop_count = r_drop_count;

`ifdef DTREE_CLASS_COUNT_EN
    localparam int unsigned NUM_CLASSES = 1 << LABEL_WIDTH;

    logic [COUNT_WIDTH-1:0] r_class_cnt [NUM_CLASSES];
    logic [COUNT_WIDTH-1:0] w_class_inc;

    always_comb begin
        w_class_inc = COUNT_WIDTH'(sat_inc(32'(r_class_cnt[w_lookup]), COUNT_WIDTH));
    end

    // Every lookup counts, dropped or not; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                r_class_cnt[i] <= '0;
            end
        end else if (count_clear) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                r_class_cnt[i] <= '0;
            end
        end else if (r_s1_valid) begin
            r_class_cnt[w_lookup] <= w_class_inc;
        end
    end

    assign count_out = r_class_cnt[count_sel];
`endif

endmodule

// File: tb/tb_dtree_label_queue.sv
// Directed bench for dtree_label_queue: table-driven lookups plus hand-written
// sequences for fill/drop, full push+pop, write/lookup collision, class counters
// (when DTREE_CLASS_COUNT_EN is defined) and asynchronous reset mid-stream.
module tb_dtree_label_queue;
    import dtree_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  level = '0;
    logic [1:0]  path = '0;
    logic        in_valid = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [1:0]  cfg_label = '0;
    logic [1:0]  label;
    logic        label_valid;
    logic        label_ready = 1'b0;
    logic [15:0] drop_count;
`ifdef DTREE_CLASS_COUNT_EN
    logic [1:0]  count_sel = '0;
    logic [15:0] count_out;
    logic        count_clear = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dtree_label_queue #(
        .FEATURES    (3),
        .LABEL_WIDTH (2),
        .DEPTH       (8),
        .COUNT_WIDTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .level       (level),
        .path        (path),
        .in_valid    (in_valid),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_label   (cfg_label),
        .label       (label),
        .label_valid (label_valid),
        .label_ready (label_ready),
`ifdef DTREE_CLASS_COUNT_EN
        .count_sel   (count_sel),
        .count_out   (count_out),
        .count_clear (count_clear),
`endif
        .drop_count  (drop_count)
    );

    typedef struct {
        logic [1:0] lvl;
        logic [1:0] pth;
        label_t     exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [1:0] lbl);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_label = lbl;
        step();
        cfg_we    = 1'b0;
    endtask

    // Single strobe into an empty FIFO; label appears two edges later, then pop it.
    task automatic lookup_one(input logic [3:0] idx, input logic [1:0] exp, input string name);
        {level, path} = idx;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check({name, "_valid"}, 32'(label_valid), 32'd1);
        check({name, "_label"}, 32'(label), 32'(exp));
        label_ready = 1'b1;
        step();
        label_ready = 1'b0;
        check({name, "_empty"}, 32'(label_valid), 32'd0);
    endtask

    initial begin
        vec_t       vecs [6];
        logic [3:0] fill_idx [10];
        logic [1:0] drain_exp [8];

        // Reset values
        #1;
        check("rst_valid", 32'(label_valid), 32'd0);
        check("rst_label", 32'(label), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
`ifdef DTREE_CLASS_COUNT_EN
        check("rst_count", 32'(count_out), 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        // First lookup: table[{1,2}] = 3, two-cycle latency
        cfg_write(4'h6, 2'd3);
        level    = 2'd1;
        path     = 2'd2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_t1_valid", 32'(label_valid), 32'd0);
        step();
        check("lat_t2_valid", 32'(label_valid), 32'd1);
        check("lat_t2_label", 32'(label), 32'd3);
        check("lat_drop", 32'(drop_count), 32'd0);
        label_ready = 1'b1;
        step();
        label_ready = 1'b0;
        check("lat_pop_empty", 32'(label_valid), 32'd0);

        // Table-driven lookups
        cfg_write(4'h0, 2'd1);
        cfg_write(4'h3, 2'd2);
        cfg_write(4'h9, 2'd3);
        cfg_write(4'hF, 2'd1);
        vecs[0] = '{lvl: 2'd0, pth: 2'd0, exp: 2'd1};
        vecs[1] = '{lvl: 2'd0, pth: 2'd3, exp: 2'd2};
        vecs[2] = '{lvl: 2'd2, pth: 2'd1, exp: 2'd3};
        vecs[3] = '{lvl: 2'd3, pth: 2'd3, exp: 2'd1};
        vecs[4] = '{lvl: 2'd1, pth: 2'd2, exp: 2'd3};
        vecs[5] = '{lvl: 2'd2, pth: 2'd2, exp: 2'd0};
        for (int i = 0; i < 6; i++) begin
            lookup_one({vecs[i].lvl, vecs[i].pth}, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Fill: 10 back-to-back strobes with the consumer stalled
        fill_idx = '{4'h0, 4'h3, 4'h9, 4'hA, 4'h0, 4'h3, 4'h9, 4'hA, 4'h0, 4'h3};
        for (int i = 0; i < 10; i++) begin
            {level, path} = fill_idx[i];
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        check("fill_drop", 32'(drop_count), 32'd2);
        check("fill_valid", 32'(label_valid), 32'd1);
        check("fill_head", 32'(label), 32'd1);

        // Full FIFO: push (label 3) and pop land on the same edge
        {level, path} = 4'h9;
        in_valid = 1'b1;
        step();
        in_valid    = 1'b0;
        label_ready = 1'b1;
        step();
        label_ready = 1'b0;
        check("fullpp_drop", 32'(drop_count), 32'd2);
        check("fullpp_head", 32'(label), 32'd2);

        // Drain: remaining 7 original labels in order, then the one pushed while full
        drain_exp = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
        label_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #3;
            check($sformatf("drain%0d_valid", i), 32'(label_valid), 32'd1);
            check($sformatf("drain%0d_label", i), 32'(label), 32'(drain_exp[i]));
            step();
        end
        label_ready = 1'b0;
        check("drain_empty", 32'(label_valid), 32'd0);
        check("drain_drop", 32'(drop_count), 32'd2);

        // Table write collides with a stage-2 lookup of the same index
        cfg_write(4'h5, 2'd2);
        {level, path} = 4'h5;
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        cfg_we    = 1'b1;
        cfg_addr  = 4'h5;
        cfg_label = 2'd1;
        step();
        cfg_we = 1'b0;
        check("coll_valid", 32'(label_valid), 32'd1);
        check("coll_old_label", 32'(label), 32'd2);
        label_ready = 1'b1;
        step();
        label_ready = 1'b0;
        lookup_one(4'h5, 2'd1, "coll_new");

`ifdef DTREE_CLASS_COUNT_EN
        // Class counters: three label-1 lookups, then clear against a lookup
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        count_sel   = 2'd1;
        label_ready = 1'b1;
        {level, path} = 4'h5;
        in_valid = 1'b1;
        step();
        step();
        step();
        in_valid = 1'b0;
        step();
        check("cnt_class1", 32'(count_out), 32'd3);
        count_sel = 2'd0;
        #1;
        check("cnt_class0", 32'(count_out), 32'd0);
        count_sel = 2'd1;
        in_valid  = 1'b1;
        step();
        in_valid    = 1'b0;
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        check("cnt_clear_wins", 32'(count_out), 32'd0);
        step();
        label_ready = 1'b0;
        check("cnt_fifo_empty", 32'(label_valid), 32'd0);
`endif

        // Asynchronous reset with 4 labels queued
        {level, path} = 4'h0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("arst_pre_valid", 32'(label_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(label_valid), 32'd0);
        check("arst_label", 32'(label), 32'd0);
        check("arst_drop", 32'(drop_count), 32'd0);
        #1;
        reset = 1'b1;
        step();
        step();
        check("arst_post_valid", 32'(label_valid), 32'd0);
        lookup_one(4'h0, 2'd0, "arst_table0");
        lookup_one(4'h6, 2'd0, "arst_table6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dtree_label_queue.md
# dtree_label_queue

Downstream stage of the decision-tree classifier. Consumes the tree's leaf result (`level`, `path`, `out_valid`), maps each leaf to a class label through a runtime-writable table, and buffers labels in a small FIFO drained by a valid/ready consumer. It also keeps a saturating drop counter and, optionally, per-class spike counters.

## Interface
- `FEATURES`, 3: tree feature count; sets `LW = $clog2(FEATURES)`, the width of `level` and `path`.
- `LABEL_WIDTH`, 2: class label width.
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `COUNT_WIDTH`, 16: width of the drop counter and class counters.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `level`  in  LW  leaf depth from the tree.
- `path`  in  LW  leaf path bits from the tree.
- `in_valid`  in  1  one-cycle strobe; `level`/`path` are valid this cycle.
- `cfg_we`  in  1  label table write enable.
- `cfg_addr`  in  2*LW  leaf index to write.
- `cfg_label`  in  LABEL_WIDTH  label value to write.
- `label`  out  LABEL_WIDTH  FIFO head label.
- `label_valid`  out  1  FIFO not empty.
- `label_ready`  in  1  consumer accepts the head when `label_valid` is high.
- `drop_count`  out  COUNT_WIDTH  number of labels lost to a full FIFO; saturating.
- `count_sel`  in  LABEL_WIDTH  class counter select (exists only with the macro).
- `count_out`  out  COUNT_WIDTH  selected class count (exists only with the macro).
- `count_clear`  in  1  synchronous clear of all class counters (exists only with the macro).

## Operation
- Leaf index is `{level, path}`, width 2*LW. The table holds 2^(2*LW) entries of LABEL_WIDTH bits; every entry resets to 0.
- Stage 1: on `in_valid`, register the leaf index and set `s1_valid`. `s1_valid` clears on the next cycle unless `in_valid` is asserted again. Back-to-back strobes are sustained at one per cycle.
- Stage 2: when `s1_valid` is high, read the table combinationally at the registered index. The result is the push request.
- Table write: takes effect on the edge. A same-cycle lookup of the written address returns the old value.
- Push accepted when the FIFO is not full, or when it is full and a pop happens in the same cycle.
- Push rejected: label discarded; `drop_count` increments and saturates at all-ones.
- Pop: occurs when `label_valid && label_ready`. `label_ready` while empty has no effect.
- Push and pop in the same cycle keep occupancy unchanged. Order is strict FIFO.
- Pointers are log2(DEPTH)+1 bits wide. Full means MSBs differ and the remaining bits are equal; empty means the pointers are equal. Wrap-around is natural modulo 2*DEPTH.
- `label` is the registered head entry. Its value is don't-care while empty; the bench must not check it then.
- Reset mid-operation: all entries are lost, including in-flight `s1_valid`. Outputs return to reset values immediately (asynchronously).

## Timing
- Reset values: `label` = 0, `label_valid` = 0, `drop_count` = 0, `count_out` = 0. Table cleared; pointers 0; `s1_valid` = 0.
- Latency: `in_valid` in cycle t, FIFO empty, gives `label_valid` high in cycle t+2.
- A pop in cycle t exposes the next head in cycle t+1.
- Throughput: one label per cycle in and out.

## Configuration
- `DTREE_CLASS_COUNT_EN` defined:
  - 2^LABEL_WIDTH saturating counters of COUNT_WIDTH bits.
  - Counter[label] increments on every stage-2 lookup, including dropped labels.
  - `count_out` = counter[`count_sel`], combinational.
  - `count_clear` zeroes all counters at the edge and wins over a same-cycle increment.
- Not defined: the counters and the `count_sel`/`count_out`/`count_clear` ports are absent. All other behaviour is identical.

## Structure
- Package `dtree_pkg` holds:
  - leaf-index width function (2*$clog2(FEATURES));
  - `label_t` typedef;
  - saturating-increment function shared by `drop_count` and the class counters.
- One sub-module, `label_fifo`: synchronous FIFO with DEPTH/WIDTH parameters and push, pop, full, empty, head. The table, stage-1 register and counters stay in the top.

## Test plan
- Reset, then write table[{1,2}] = 3; pulse `in_valid` with level=1, path=2 at cycle 5 -> `label_valid` high at cycle 7 with `label` = 3; `drop_count` = 0.
- `label_ready` held 0; 10 back-to-back strobes with DEPTH=8 -> 8 labels queued, `drop_count` = 2; drain returns the first 8 labels in order.
- FIFO full, push and pop in the same cycle -> push accepted, occupancy stays 8, `drop_count` unchanged.
- Write table[5] = 1 in the same cycle stage 2 looks up index 5, where table[5] was 2 -> queued label = 2; a later lookup gives 1.
- With `DTREE_CLASS_COUNT_EN`: 3 lookups yielding label 1 -> `count_sel`=1 gives `count_out` = 3. Assert `count_clear` together with a label-1 lookup -> 0 on the next cycle.
- Assert `reset` low mid-stream with 4 entries queued -> `label_valid` drops without a clock edge. After release, `label_valid` = 0 and the table reads 0.
